// File: rtl/shift_right_pipe.sv
// Pipelined right barrel shifter: stage k shifts by 2^k, valid/ready on both ends.
// Optional rotate mode (in_rot port) is enabled by defining SHR_ROTATE_EN.
module shift_right_pipe #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_arith,
`ifdef SHR_ROTATE_EN
  input  logic             in_rot,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic [SHW-1:0]   valid_q, valid_d;
  logic [WIDTH-1:0] data_q  [SHW];
  logic [WIDTH-1:0] data_d  [SHW];
  logic [SHW-1:0]   shamt_q [SHW];
  logic [SHW-1:0]   shamt_d [SHW];
  logic [SHW-1:0]   sign_q, sign_d;
  logic [SHW-1:0]   arith_q, arith_d;
`ifdef SHR_ROTATE_EN
  logic [SHW-1:0]   rot_q, rot_d;
  logic [SHW-1:0]   src_rot;
`endif

  logic [SHW-1:0]   adv;
  logic [SHW-1:0]   src_valid;
  logic [WIDTH-1:0] src_data  [SHW];
  logic [SHW-1:0]   src_shamt [SHW];
  logic [SHW-1:0]   src_sign;
  logic [SHW-1:0]   src_arith;
  logic [WIDTH-1:0] stage_res [SHW];

  // Ready chain accumulated from the output end without reading adv back.
  always_comb begin
    logic acc;
    acc = out_ready;
    adv = '0;
    for (int unsigned j = 0; j < SHW; j++) begin
      acc = !valid_q[SHW-1-j] || acc;
      adv[SHW-1-j] = acc;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];

  // Stage inputs: S0 takes the port, every other stage takes its upstream register.
  always_comb begin
    src_valid    = '0;
    src_sign     = '0;
    src_arith    = '0;
    src_valid[0] = in_valid;
    src_data[0]  = in_data;
    src_shamt[0] = in_shamt;
    src_sign[0]  = in_data[WIDTH-1];
    src_arith[0] = in_arith;
`ifdef SHR_ROTATE_EN
    src_rot      = '0;
    src_rot[0]   = in_rot;
`endif
    for (int unsigned k = 1; k < SHW; k++) begin
      src_valid[k] = valid_q[k-1];
      src_data[k]  = data_q[k-1];
      src_shamt[k] = shamt_q[k-1];
      src_sign[k]  = sign_q[k-1];
      src_arith[k] = arith_q[k-1];
`ifdef SHR_ROTATE_EN
      src_rot[k]   = rot_q[k-1];
`endif
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < SHW; k++) begin
      int unsigned s;
      logic        fill;
      s    = 32'd1 << k;
      fill = src_arith[k] & src_sign[k];
      stage_res[k] = src_data[k];
      if (src_shamt[k][k]) begin
`ifdef SHR_ROTATE_EN
        if (src_rot[k])
          stage_res[k] = (src_data[k] >> s) | (src_data[k] << (WIDTH - s));
        else
`endif
          stage_res[k] = (src_data[k] >> s) | (fill ? ~(ONES >> s) : '0);
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    sign_d  = sign_q;
    arith_d = arith_q;
`ifdef SHR_ROTATE_EN
    rot_d   = rot_q;
`endif
    for (int unsigned k = 0; k < SHW; k++) begin
      data_d[k]  = data_q[k];
      shamt_d[k] = shamt_q[k];
      if (adv[k]) begin
        valid_d[k] = src_valid[k];
        if (src_valid[k]) begin
          data_d[k]  = stage_res[k];
          shamt_d[k] = src_shamt[k];
          sign_d[k]  = src_sign[k];
          arith_d[k] = src_arith[k];
`ifdef SHR_ROTATE_EN
          rot_d[k]   = src_rot[k];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      sign_q  <= '0;
      arith_q <= '0;
`ifdef SHR_ROTATE_EN
      rot_q   <= '0;
`endif
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      sign_q  <= sign_d;
      arith_q <= arith_d;
`ifdef SHR_ROTATE_EN
      rot_q   <= rot_d;
`endif
      for (int unsigned k = 0; k < SHW; k++) begin
        data_q[k]  <= data_d[k];
        shamt_q[k] <= shamt_d[k];
      end
    end
  end

endmodule

// File: doc/shift_right_pipe.md
Name: shift_right_pipe

Overview:
- Pipelined right barrel shifter: logical or arithmetic shift of a WIDTH-bit operand by a SHW-bit amount.
- Complements the existing left-shift stage chain in the ALU core.
- One register stage per shift-amount bit: stage k conditionally shifts by 2^k.
- Valid/ready handshake on both ends; full backpressure, 1 result/cycle throughput.

Parameters:
- WIDTH, 64, operand/result width in bits (power of 2, >= 8)
- SHW, 6, shift-amount width; must equal log2(WIDTH); also the pipeline depth

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand offered
- in_ready  output  1  pipeline accepts operand this cycle
- in_data  input  WIDTH  operand
- in_shamt  input  SHW  shift amount, 0..WIDTH-1
- in_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result

Behaviour:
- Reset (rst_n low at a clk edge): all stage valid bits cleared, all data/shamt/mode registers cleared. out_valid=0, out_data=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation: in-flight operands are discarded, no result is emitted, and nothing is held over.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Stages S0..S(SHW-1). Each stage holds valid, data, residual shamt and arith bit.
- Stage k captures the previous stage's data (S0 captures in_data) and shifts it right by 2^k when shamt[k]=1; otherwise passes it unchanged.
- Fill bits: the sign bit of the original operand when arith=1, else 0.
  - The sign bit is captured at S0 and carried down the pipe, so the fill is correct after multiple stages.
- out_data and out_valid are driven directly from S(SHW-1) registers; no combinational path from in_data to out_data.
- Stage k advance: adv[k] = !valid[k] || adv[k+1].
  - adv[SHW] = out_ready.
  - in_ready = adv[0].
  - This is a combinational ready chain; no bubbles are required.
- When a stage advances and its upstream is invalid, its valid clears (bubble).
- Latency: SHW cycles from input transfer to out_valid with no stall (6 for defaults).
- Stall: out_ready=0 with the pipe full gives in_ready=0. Contents and out_data stay stable while out_valid && !out_ready.
- Simultaneous input and output transfer in the same cycle with a full pipe: allowed, throughput is preserved.
- Order: strictly FIFO; no reordering.
- shamt=0: result equals operand in both modes.

Optional Feature:
- Macro SHR_ROTATE_EN.
- Defined:
  - Adds input port in_rot (1 bit), carried alongside arith.
  - When in_rot=1, stage k rotates right by 2^k: vacated MSBs are filled with the bits shifted out of the LSB end, and in_arith is ignored.
  - When in_rot=0, behaviour is identical to the undefined case.
- Undefined:
  - No in_rot port; logical/arithmetic shift only.
  - No rotate logic is synthesized.

Test Plan:
- Logical: in_data=0x8000_0000_0000_00F0, shamt=4, arith=0, out_ready=1 -> out_data=0x0800_0000_0000_000F, out_valid exactly 6 cycles after acceptance.
- Arithmetic: in_data=0x8000_0000_0000_0000, shamt=63, arith=1 -> 0xFFFF_FFFF_FFFF_FFFF. Same operand with arith=0 -> 0x0000_0000_0000_0001.
- Streaming: 20 back-to-back operands with shamt=0..19, out_ready=1 -> in_ready constantly 1, results in order, one per cycle after the 6-cycle fill.
- Backpressure:
  - Hold out_ready=0 for 10 cycles while driving in_valid=1 -> exactly 6 operands accepted, in_ready=0 afterwards, and out_data held stable.
  - Release out_ready -> all 6 results drain in order with no loss or duplication.
- Reset mid-flight: 3 operands in the pipe, rst_n=0 for 1 cycle -> out_valid=0 and out_data=0 next cycle, none of the 3 results ever emitted, and in_ready=1.
- SHR_ROTATE_EN: in_data=0x0000_0000_0000_0001, shamt=1, rot=1 -> 0x8000_0000_0000_0000.
